// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns {g,f,e,d,c,b,a},
// hex decode helper and the scan FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: nibble + dp + dark -> active-low cathode {dp,g..a}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] cathode
);

  always_comb begin
    cathode = {~dp, (dark ? SEG_OFF : hex_to_seg(nibble))};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with dead time between digits,
// leading-zero suppression and frame-boundary (tear-free) data update.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned LZ_SUPPRESS  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            cathode,
  output logic                  frame_done
);

  localparam int unsigned TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam int unsigned IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [TW-1:0] DRIVE_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [4*N_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*N_DIGITS-1:0] act_value_q, act_value_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]            cathode_q, cathode_d;
  logic                  frame_done_q, frame_done_d;

  logic       blank_end;
  logic       boundary;
  logic [3:0] dec_nibble;
  logic       dec_dp;
  logic       dec_dark;
  logic       lz_dark;
  logic [7:0] dec_cathode;

  // Pending/active path kept apart from the FSM block so the decoder can look
  // at the data that becomes active on the same edge the digit is driven.
  always_comb begin
    blank_end = (state_q == ST_BLANK) && (timer_q == BLANK_LAST);
    boundary  = blank_end && (idx_q == '0);

    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
    end

    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (boundary) begin
      act_value_d = pend_value_d;
      act_dp_d    = pend_dp_d;
      act_blank_d = pend_blank_d;
    end
  end

  always_comb begin
    dec_nibble = act_value_d[4*idx_q +: 4];
    lz_dark    = (LZ_SUPPRESS != 0) && (idx_q != '0) &&
                 ((act_value_d >> {idx_q, 2'b00}) == '0);
    dec_dark   = act_blank_d[idx_q] | lz_dark;
    dec_dp     = act_dp_d[idx_q] & ~act_blank_d[idx_q];
  end

  seg7_decode u_decode (
    .nibble  (dec_nibble),
    .dp      (dec_dp),
    .dark    (dec_dark),
    .cathode (dec_cathode)
  );

  // Outputs only move on the edge of a state change, so a digit's anode and
  // cathode switch together and the dead time separates adjacent anodes.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    anode_d      = anode_q;
    cathode_d    = cathode_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (blank_end) begin
          state_d   = ST_DRIVE;
          timer_d   = '0;
          anode_d   = ~(N_DIGITS'(1) << idx_q);
          cathode_d = dec_cathode;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_q == DRIVE_LAST) begin
          state_d      = ST_BLANK;
          timer_d      = '0;
          anode_d      = '1;
          cathode_d    = '1;
          idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          frame_done_d = (idx_q == IDX_LAST);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_BLANK;
        timer_d   = '0;
        anode_d   = '1;
        cathode_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      timer_q      <= '0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      anode_q      <= '1;
      cathode_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign frame_done = frame_done_q;

endmodule
